// File: rtl/fwd_pkg.sv
// Shared select codes and stage-entry control layout for the forwarding/hazard unit.
package fwd_pkg;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    // Control part of every stage entry. Packed layouts built on it:
    //   EXE     : {src[NUM_SRC], used[NUM_SRC], dest, stage_ctl_t}
    //   MEM, WB : {dest, stage_ctl_t}
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_read;
    } stage_ctl_t;

    localparam int CTL_W = $bits(stage_ctl_t);

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request, pipeline control and forwarding/stall results between the core and the unit.
interface fwd_hazard_unit_if #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                       freeze;
    logic                       flush;
    logic                       fwd_en;
    logic                       id_valid;
    logic [REG_W*NUM_SRC-1:0]   id_src;
    logic [NUM_SRC-1:0]         id_src_used;
    logic [REG_W-1:0]           id_dest;
    logic                       id_wb_en;
    logic                       id_mem_read;
    logic                       hazard_stall;
    logic [2*NUM_SRC-1:0]       sel_src;
    logic [CNT_W-1:0]           stall_count;

    modport master (
        output freeze, flush, fwd_en, id_valid, id_src, id_src_used,
               id_dest, id_wb_en, id_mem_read,
        input  hazard_stall, sel_src, stall_count
    );

    modport slave (
        input  freeze, flush, fwd_en, id_valid, id_src, id_src_used,
               id_dest, id_wb_en, id_mem_read,
        output hazard_stall, sel_src, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit_stage_reg.sv
// One pipeline tag entry: holds on freeze, loads or bubbles otherwise, clears on reset.
module fwd_stage_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    // NOTE: state updates use <= so every stage samples the pre-edge value of the stage before it.
    // A bubble clears the whole entry, so stale tags in an invalid slot can never match.
    always_ff @(posedge clk) begin
        if (!rst_n)       q <= '0;
        else if (!freeze) q <= load ? d : '0;
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// EXE/MEM/WB destination-tag pipeline with per-operand forwarding selects and ID hazard detection.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_unit_if.slave   bus
);
    localparam int TAG_W = REG_W + CTL_W;
    localparam int EXE_W = REG_W * NUM_SRC + NUM_SRC + TAG_W;

    logic [EXE_W-1:0]         exe_d, exe_q;
    logic [TAG_W-1:0]         mem_q, wb_q;
    logic                     exe_load;

    logic [REG_W*NUM_SRC-1:0] exe_src;
    logic [NUM_SRC-1:0]       exe_used;
    logic [REG_W-1:0]         exe_dest, mem_dest, wb_dest;
    stage_ctl_t               id_ctl, exe_ctl, mem_ctl, wb_ctl;

    logic [NUM_SRC-1:0]       src_hit;
    logic [2*NUM_SRC-1:0]     sel_src;
    logic                     hazard_stall;
    logic [CNT_W-1:0]         stall_count;
    logic                     unused_mem_read;

    function automatic logic writes(stage_ctl_t c, logic [REG_W-1:0] dest, logic [REG_W-1:0] r);
        return c.valid & c.wb_en & (dest == r);
    endfunction

    assign id_ctl   = '{valid: bus.id_valid, wb_en: bus.id_wb_en, mem_read: bus.id_mem_read};
    assign exe_d    = {bus.id_src, bus.id_src_used, bus.id_dest, id_ctl};
    assign exe_load = bus.id_valid & ~hazard_stall & ~bus.flush;

    fwd_stage_reg #(.DATA_W(EXE_W)) u_exe (
        .clk(clk), .rst_n(rst_n), .freeze(bus.freeze), .load(exe_load), .d(exe_d), .q(exe_q)
    );
    fwd_stage_reg #(.DATA_W(TAG_W)) u_mem (
        .clk(clk), .rst_n(rst_n), .freeze(bus.freeze), .load(1'b1), .d(exe_q[TAG_W-1:0]), .q(mem_q)
    );
    fwd_stage_reg #(.DATA_W(TAG_W)) u_wb (
        .clk(clk), .rst_n(rst_n), .freeze(bus.freeze), .load(1'b1), .d(mem_q), .q(wb_q)
    );

    assign {exe_src, exe_used, exe_dest, exe_ctl} = exe_q;
    assign {mem_dest, mem_ctl} = mem_q;
    assign {wb_dest, wb_ctl}   = wb_q;
    // Load flag only matters while the producer sits in EXE.
    assign unused_mem_read = mem_ctl.mem_read ^ wb_ctl.mem_read;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_W-1:0] ex_s;
        logic [REG_W-1:0] id_s;
        logic             fwd_ok;

        assign ex_s   = exe_src[g*REG_W +: REG_W];
        assign id_s   = bus.id_src[g*REG_W +: REG_W];
        assign fwd_ok = exe_ctl.valid & exe_used[g] & bus.fwd_en;

        // MEM holds the younger result, so it wins over WB.
        assign sel_src[2*g +: 2] = !fwd_ok                        ? SEL_RF  :
                                   writes(mem_ctl, mem_dest, ex_s) ? SEL_MEM :
                                   writes(wb_ctl, wb_dest, ex_s)   ? SEL_WB  : SEL_RF;

        assign src_hit[g] = bus.id_src_used[g] &
            (bus.fwd_en ? (writes(exe_ctl, exe_dest, id_s) & exe_ctl.mem_read)
                        : (writes(exe_ctl, exe_dest, id_s) |
                           writes(mem_ctl, mem_dest, id_s) |
                           writes(wb_ctl, wb_dest, id_s)));
    end

    assign hazard_stall = bus.id_valid & ~bus.flush & (|src_hit);

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (!bus.freeze && hazard_stall && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end

    assign bus.sel_src      = sel_src;
    assign bus.hazard_stall = hazard_stall;
    assign bus.stall_count  = stall_count;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against an instruction-level pipeline model.
module tb_fwd_hazard_unit;
    localparam int REG_W   = 5;
    localparam int NUM_SRC = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();
    fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        bit valid;
        bit wb_en;
        bit mem_read;
        int dest;
        int src[NUM_SRC];
        bit used[NUM_SRC];
    } ins_t;

    // Model pipeline: index 0 = EXE, 1 = MEM, 2 = WB.
    ins_t st[3];
    ins_t cur;
    bit   m_freeze, m_flush, m_fwd, model_known, m_last_stall;
    int   m_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [2*NUM_SRC-1:0] last_sel;
    logic                 last_stall;
    logic [CNT_W-1:0]     last_cnt;
    int   nstall;

    function automatic ins_t mk(bit v, int d, bit wb, bit ld, int s0, int s1, int s2, bit [2:0] u);
        ins_t e;
        e.valid = v; e.dest = d; e.wb_en = wb; e.mem_read = ld;
        e.src[0] = s0; e.src[1] = s1; e.src[2] = s2;
        for (int i = 0; i < NUM_SRC; i++) e.used[i] = u[i];
        return e;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 3'b000);
    endfunction

    function automatic bit writes(ins_t e, int r);
        return e.valid && e.wb_en && e.dest == r;
    endfunction

    function automatic int exp_sel(int i);
        if (!st[0].valid || !st[0].used[i] || !m_fwd) return 0;
        if (writes(st[1], st[0].src[i])) return 2;
        if (writes(st[2], st[0].src[i])) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit hit = 0;
        if (!cur.valid || m_flush) return 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!cur.used[i]) continue;
            if (m_fwd) hit |= writes(st[0], cur.src[i]) && st[0].mem_read;
            else       hit |= writes(st[0], cur.src[i]) || writes(st[1], cur.src[i])
                              || writes(st[2], cur.src[i]);
        end
        return hit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample/compare at negedge, advance model at posedge.
    task automatic cycle();
        bit es;
        bus.freeze      = m_freeze;
        bus.flush       = m_flush;
        bus.fwd_en      = m_fwd;
        bus.id_valid    = cur.valid;
        bus.id_dest     = REG_W'(cur.dest);
        bus.id_wb_en    = cur.wb_en;
        bus.id_mem_read = cur.mem_read;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.id_src[i*REG_W +: REG_W] = REG_W'(cur.src[i]);
            bus.id_src_used[i]           = cur.used[i];
        end
        @(negedge clk);
        last_sel   = bus.sel_src;
        last_stall = bus.hazard_stall;
        last_cnt   = bus.stall_count;
        es = exp_stall();
        if (model_known) begin
            check("hazard_stall", 32'(last_stall), 32'(es));
            for (int i = 0; i < NUM_SRC; i++)
                check($sformatf("sel_src[%0d]", i), 32'(last_sel[2*i +: 2]), 32'(exp_sel(i)));
            check("stall_count", 32'(last_cnt), 32'(m_cnt));
        end
        m_last_stall = es;
        @(posedge clk);
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) st[s] = nop();
            m_cnt = 0;
            model_known = 1;
        end else if (!m_freeze) begin
            st[2] = st[1];
            st[1] = st[0];
            st[0] = (cur.valid && !es && !m_flush) ? cur : nop();
            if (es && m_cnt != CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    // Hold an instruction in ID until it is accepted; counts the stall cycles the DUT shows.
    task automatic issue(input ins_t i, output int n);
        n = 0;
        cur = i;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (last_stall === 1'b1) n++;
            if (!m_last_stall) break;
        end
        cur = nop();
    endtask

    task automatic do_reset();
        rst_n = 0;
        cur = mk(1, 3, 1, 0, 0, 0, 0, 3'b000);
        repeat (2) cycle();
        rst_n = 1;
        cur = nop();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 3; s++) st[s] = nop();
        cur = nop();
        m_freeze = 0; m_flush = 0; m_fwd = 1; m_cnt = 0; model_known = 0;
        @(posedge clk); #1;

        // Reset while ID presents a valid writer.
        do_reset();
        cycle();
        check("reset sel", 32'(last_sel), 0);
        check("reset stall", 32'(last_stall), 0);
        check("reset count", 32'(last_cnt), 0);

        // ALU chain: back-to-back forwards from MEM, one gap forwards from WB.
        issue(mk(1, 1, 1, 0, 0, 0, 0, 3'b000), nstall);
        issue(mk(1, 2, 1, 0, 1, 1, 0, 3'b011), nstall);
        cycle();
        check("alu chain mem", 32'(last_sel), 32'(6'b001010));
        issue(mk(1, 1, 1, 0, 0, 0, 0, 3'b000), nstall);
        cycle();
        issue(mk(1, 2, 1, 0, 1, 1, 0, 3'b011), nstall);
        cycle();
        check("alu chain wb", 32'(last_sel), 32'(6'b000101));

        // MEM beats WB; an unused operand with a matching address stays on the register file.
        issue(mk(1, 5, 1, 0, 0, 0, 0, 3'b000), nstall);
        issue(mk(1, 5, 1, 0, 0, 0, 0, 3'b000), nstall);
        issue(mk(1, 7, 1, 0, 5, 5, 5, 3'b001), nstall);
        cycle();
        check("priority/mask", 32'(last_sel), 32'(6'b000010));

        // Load-use: one stall cycle.
        do_reset();
        issue(mk(1, 4, 1, 1, 0, 0, 0, 3'b000), nstall);
        issue(mk(1, 6, 1, 0, 4, 0, 0, 3'b001), nstall);
        check("load-use stalls", nstall, 1);
        check("load-use count", 32'(last_cnt), 1);
        cycle();
        cycle();

        // Flush on the would-be stall cycle suppresses it.
        do_reset();
        issue(mk(1, 4, 1, 1, 0, 0, 0, 3'b000), nstall);
        cur = mk(1, 6, 1, 0, 4, 0, 0, 3'b001);
        m_flush = 1;
        cycle();
        check("flush beats stall", 32'(last_stall), 0);
        m_flush = 0;
        issue(mk(1, 6, 1, 0, 4, 0, 0, 3'b001), nstall);
        cycle();

        // Stall-only mode: three stall cycles, then no forwarding.
        do_reset();
        m_fwd = 0;
        issue(mk(1, 1, 1, 0, 0, 0, 0, 3'b000), nstall);
        issue(mk(1, 2, 1, 0, 1, 0, 0, 3'b001), nstall);
        check("no-fwd stalls", nstall, 3);
        check("no-fwd count", 32'(last_cnt), 3);
        cycle();
        check("no-fwd sel", 32'(last_sel), 0);

        // Freeze for two cycles in the middle of the stall.
        do_reset();
        issue(mk(1, 1, 1, 0, 0, 0, 0, 3'b000), nstall);
        cur = mk(1, 2, 1, 0, 1, 0, 0, 3'b001);
        cycle();
        m_freeze = 1;
        cycle();
        cycle();
        check("freeze count hold", 32'(last_cnt), 1);
        check("freeze stall shown", 32'(last_stall), 1);
        m_freeze = 0;
        issue(mk(1, 2, 1, 0, 1, 0, 0, 3'b001), nstall);
        check("post-freeze stalls", nstall, 2);
        check("post-freeze count", 32'(last_cnt), 3);

        // Reset in the middle of a stall.
        issue(mk(1, 1, 1, 0, 0, 0, 0, 3'b000), nstall);
        cur = mk(1, 2, 1, 0, 1, 0, 0, 3'b001);
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        cur = nop();
        cycle();
        check("mid-stall reset sel", 32'(last_sel), 0);
        check("mid-stall reset stall", 32'(last_stall), 0);
        check("mid-stall reset count", 32'(last_cnt), 0);

        // Saturation: 21 stall cycles on a 4-bit counter.
        for (int r = 0; r < 7; r++) begin
            issue(mk(1, 1, 1, 0, 0, 0, 0, 3'b000), nstall);
            issue(mk(1, 2, 1, 0, 1, 0, 0, 3'b001), nstall);
        end
        cycle();
        check("saturated count", 32'(last_cnt), CNT_MAX);

        // Third operand forwarding with 5-bit register addresses.
        do_reset();
        m_fwd = 1;
        issue(mk(1, 20, 1, 0, 0, 0, 0, 3'b000), nstall);
        issue(mk(1, 9, 1, 0, 3, 7, 20, 3'b100), nstall);
        cycle();
        check("third operand", 32'(last_sel), 32'(6'b100000));

        // Random traffic over a small register set to make tag matches frequent.
        for (int n = 0; n < 400; n++) begin
            cur = mk($urandom_range(9, 0) < 8, $urandom_range(3, 0), $urandom_range(1, 0),
                     $urandom_range(3, 0) == 0, $urandom_range(3, 0), $urandom_range(3, 0),
                     $urandom_range(3, 0), 3'($urandom_range(7, 0)));
            m_flush  = $urandom_range(9, 0) == 0;
            m_freeze = $urandom_range(6, 0) == 0;
            if ($urandom_range(19, 0) == 0) m_fwd = ~m_fwd;
            rst_n = ($urandom_range(49, 0) != 0);
            cycle();
        end
        rst_n = 1; m_freeze = 0; m_flush = 0; cur = nop();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

- Parametrised successor to the two-source forwarding selector.
- Keeps its own EXE/MEM/WB destination-tag pipeline, so the core no longer routes dest/WB_EN back from later stages.
- Computes per-source forwarding selects for N EXE-stage operands, detects load-use and no-forward hazards at ID, and counts stall cycles.
- Sits beside the ID/EXE pipeline registers of the ARM32 core.

## Interface
Parameters:
- REG_W, 4: register-address width.
- NUM_SRC, 2: number of source operands per instruction.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- freeze  in  1  global pipeline freeze (memory wait); holds all state.
- flush  in  1  branch taken; kills the instruction entering EXE.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  REG_W*NUM_SRC  ID source addresses; operand i is at [i*REG_W +: REG_W].
- id_src_used  in  NUM_SRC  operand i is actually read.
- id_dest  in  REG_W  ID destination register.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_read  in  1  ID instruction is a load.
- hazard_stall  out  1  hold PC/IF/ID and bubble EXE this cycle.
- sel_src  out  2*NUM_SRC  per EXE operand: 2 = from MEM, 1 = from WB, 0 = register file.
- stall_count  out  CNT_W  saturating count of hazard_stall cycles.

## Operation
- Internal stage entries EXE, MEM, WB, each holding {valid, dest, wb_en, mem_read}. EXE also holds src[NUM_SRC] and used[NUM_SRC].
- Advance (freeze=0):
  - WB <= MEM, MEM <= EXE.
  - EXE <= ID fields when id_valid & !hazard_stall & !flush; otherwise EXE <= bubble (valid=0).
- freeze=1: no entry changes and stall_count holds. Outputs still reflect current registers.
- A stage "writes r" iff valid & wb_en & dest==r.
- Forwarding select, per operand i, using the EXE entry:
  - Zero if the operand is unused or EXE is invalid.
  - Zero if fwd_en=0.
  - Otherwise MEM writes src_i -> 2; else WB writes src_i -> 1; else 0.
  - MEM has priority over WB.
- hazard_stall = id_valid & !flush & (some used ID operand i meets the rule for the current mode):
  - fwd_en=1: EXE writes id_src_i and EXE.mem_read=1 (load-use).
  - fwd_en=0: any of EXE, MEM or WB writes id_src_i.
- flush=1 forces hazard_stall=0. Flush has priority over stall.
- stall_count increments when hazard_stall & !freeze, saturating at all-ones. It never wraps.
- Changing fwd_en mid-run takes effect on the next combinational evaluation; stage contents are not cleared.

## Timing
- sel_src and hazard_stall are combinational from registered stage state plus current ID/control inputs, so there is zero added latency.
- Tag pipeline latency is one cycle per stage: an instruction accepted at edge k is in EXE during cycle k+1, MEM during k+2 and WB during k+3.
- Load-use with fwd_en=1 gives exactly one stall cycle. After the bubble the load is in MEM and then forwards with sel=2.
- With fwd_en=0 a dependent instruction stalls until the producer leaves WB: up to 3 cycles.
- Reset (rst_n=0 at a clock edge), including mid-stall or during freeze:
  - All entries become invalid and stall_count=0.
  - Outputs are therefore sel_src=0 and hazard_stall=0 from the cycle after that edge.

## Structure
- Package fwd_pkg holds:
  - SEL_RF=2'd0, SEL_WB=2'd1, SEL_MEM=2'd2.
  - The stage-entry struct/field layout.
- Sub-module fwd_stage_reg: one pipeline entry with freeze, bubble and sync reset. Instantiate it three times.
- Match logic uses generate loops over NUM_SRC.

## Test plan
- **Reset:** rst_n=0 for 2 cycles while issuing id_valid=1, dest=3 -> sel_src=0, hazard_stall=0, stall_count=0 after the edge.
- **ALU chain:** issue ADD r1; then SUB r2←r1,r1 -> both sels 2 when SUB is in EXE; insert a NOP between them -> both sels 1.
- **Priority and masking:**
  - MEM and WB both write r5, EXE reads r5 -> sel 2.
  - Operand with used=0 and a matching address -> sel 0.
- **Load-use:** LDR r4; then ADD r6←r4 -> hazard_stall=1 for exactly 1 cycle, stall_count=1, then ADD sel=2. Same sequence with flush=1 on the stall cycle -> hazard_stall=0.
- **No-forward mode:** fwd_en=0, ADD r1 then ORR r2←r1 -> 3 stall cycles, then sel=0, stall_count=3. Freeze held 2 cycles mid-stall -> counter and stages unchanged.
- **Saturation:** CNT_W=4, 20 stall cycles -> stall_count=15 held. Also run with NUM_SRC=3, REG_W=5: a third-operand match -> sel[5:4]=2.
